// File: rtl/l1_mem_line_ctrl.sv
// Main-memory line controller below the L1 data cache: one fill or writeback at a time,
// fixed access latency, critical-word-first beats with a one-hot per-beat acknowledge.
module l1_mem_line_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WORDS   = 4,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wdata_valid_i,
  output logic [WORDS-1:0]  wdata_ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic [WORDS-1:0]  rdata_ack_o,
  output logic              busy_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int BASE_W = IDX_W - OFF_W;
  localparam int LAT_W  = $clog2(LATENCY + 1);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);
  localparam logic [WORDS-1:0] ACK_ONE   = WORDS'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [OFF_W-1:0]    beat_q, beat_d;
  logic                store_q, store_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [OFF_W-1:0]    start_q, start_d;

  logic                req_ready_q;
  logic                busy_q;
  logic                rdata_valid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [WORDS-1:0]    rdata_ack_q;
  logic [WORDS-1:0]    wdata_ack_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [IDX_W-1:0]    word_idx;
  logic [OFF_W-1:0]    beat_off;
  logic [IDX_W-1:0]    beat_addr;
  logic [WORDS-1:0]    beat_onehot;
  logic                mem_we;
  logic                rd_fire;
  logic                unused_addr_bits;

  // Only the word-index bits select storage; higher bits alias modulo DEPTH.
  assign word_idx         = req_addr_i[IDX_W+1:2];
  assign unused_addr_bits = ^{req_addr_i[ADDR_W-1:IDX_W+2], req_addr_i[1:0]};

  // Beat offset wraps inside the line because it is exactly OFF_W bits wide.
  assign beat_off    = start_q + beat_q;
  assign beat_addr   = {base_q, beat_off};
  assign beat_onehot = ACK_ONE << beat_off;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    store_d = store_q;
    base_d  = base_q;
    start_d = start_q;
    mem_we  = 1'b0;
    rd_fire = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          store_d = req_store_i;
          base_d  = word_idx[IDX_W-1:OFF_W];
          start_d = word_idx[OFF_W-1:0];
          lat_d   = LAT_W'(LATENCY);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LAT_W'(1)) begin
          beat_d  = '0;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (store_q) begin
          if (wdata_valid_i) begin
            mem_we = 1'b1;
            beat_d = beat_q + 1'b1;
            if (beat_q == LAST_BEAT) state_d = S_DONE;
          end
        end else begin
          rd_fire = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = S_DONE;
        end
      end

      // One trailing cycle so the final beat's outputs are seen while still busy.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lat_q         <= '0;
      beat_q        <= '0;
      store_q       <= 1'b0;
      base_q        <= '0;
      start_q       <= '0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      rdata_ack_q   <= '0;
      wdata_ack_q   <= '0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      beat_q        <= beat_d;
      store_q       <= store_d;
      base_q        <= base_d;
      start_q       <= start_d;
      req_ready_q   <= (state_d == S_IDLE);
      busy_q        <= (state_d != S_IDLE);
      rdata_valid_q <= rd_fire;
      rdata_ack_q   <= rd_fire ? beat_onehot : '0;
      wdata_ack_q   <= mem_we ? beat_onehot : '0;
      if (rd_fire) rdata_q <= mem_q[beat_addr];
    end
  end

  // NOTE: the backing array has no reset; its contents survive rst_n by design.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[beat_addr] <= wdata_i;
  end

  assign req_ready_o   = req_ready_q;
  assign busy_o        = busy_q;
  assign rdata_valid_o = rdata_valid_q;
  assign rdata_o       = rdata_q;
  assign rdata_ack_o   = rdata_ack_q;
  assign wdata_ack_o   = wdata_ack_q;

endmodule

// File: tb/tb_l1_mem_line_ctrl.sv
// Directed bench for l1_mem_line_ctrl: writeback/fill timing, critical-word-first order,
// stalls, address aliasing, requests while busy and reset in the middle of a fill.
module tb_l1_mem_line_ctrl;

  localparam int L = 4;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [31:0] req_addr;
  logic [31:0] wdata;
  logic        wdata_valid;
  logic [3:0]  wdata_ack;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [3:0]  rdata_ack;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  l1_mem_line_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .WORDS  (W),
    .LATENCY(L),
    .DEPTH  (256)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_store_i  (req_store),
    .req_addr_i   (req_addr),
    .wdata_i      (wdata),
    .wdata_valid_i(wdata_valid),
    .wdata_ack_o  (wdata_ack),
    .rdata_o      (rdata),
    .rdata_valid_o(rdata_valid),
    .rdata_ack_o  (rdata_ack),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << (i % W);
  endfunction

  task automatic accept(input logic store, input logic [31:0] addr, input string name);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL %s accept: ready=%b expected 1", name, req_ready);
    else n_pass++;
    req_valid = 1'b1;
    req_store = store;
    req_addr  = addr;
    tick;
    req_valid = 1'b0;
    n_checks++;
    if ({req_ready, busy} !== 2'b01)
      $display("FAIL %s after accept: ready/busy=%b expected 01", name, {req_ready, busy});
    else n_pass++;
  endtask

  // Beat k of exp sits at exp[32*k +: 32].
  task automatic observe_read(input logic [1:0] start, input logic [127:0] exp, input string name);
    for (int e = 1; e <= L; e++) begin
      tick;
      n_checks++;
      if ({rdata_valid, req_ready, busy} !== 3'b001)
        $display("FAIL %s wait edge %0d: valid/ready/busy=%b expected 001", name, e,
                 {rdata_valid, req_ready, busy});
      else n_pass++;
    end
    for (int k = 0; k < W; k++) begin
      tick;
      n_checks++;
      if (rdata_valid !== 1'b1 || rdata !== exp[32*k +: 32] ||
          rdata_ack !== oh(int'(start) + k) || req_ready !== 1'b0)
        $display("FAIL %s beat %0d: valid=%b data=%h ack=%b ready=%b expected valid=1 data=%h ack=%b ready=0",
                 name, k, rdata_valid, rdata, rdata_ack, req_ready, exp[32*k +: 32],
                 oh(int'(start) + k));
      else n_pass++;
    end
    tick;
    n_checks++;
    if ({rdata_valid, req_ready, busy, rdata_ack} !== 7'b0_1_0_0000)
      $display("FAIL %s end: valid/ready/busy/ack=%b expected 0100000", name,
               {rdata_valid, req_ready, busy, rdata_ack});
    else n_pass++;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [127:0] exp, input string name);
    accept(1'b0, addr, name);
    observe_read(addr[3:2], exp, name);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [127:0] data, input int gap_beat,
                          input int gap_len, input string name);
    logic [1:0] start;
    logic [3:0] exp_ack;
    logic       stall;
    int         k;
    int         gaps;
    int         edge_n;
    start  = addr[3:2];
    k      = 0;
    gaps   = 0;
    edge_n = 0;
    accept(1'b1, addr, name);
    while (k < W && edge_n < 64) begin
      edge_n++;
      stall       = (edge_n > L) && (k == gap_beat) && (gaps < gap_len);
      wdata_valid = !stall;
      wdata       = stall ? 32'hDEAD_BEEF : data[32*k +: 32];
      tick;
      if (edge_n > L && !stall) begin
        exp_ack = oh(int'(start) + k);
        k++;
      end else begin
        exp_ack = 4'b0000;
        if (stall) gaps++;
      end
      n_checks++;
      if (wdata_ack !== exp_ack || req_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL %s edge %0d: ack=%b ready=%b busy=%b expected ack=%b ready=0 busy=1",
                 name, edge_n, wdata_ack, req_ready, busy, exp_ack);
      else n_pass++;
    end
    wdata_valid = 1'b0;
    wdata       = '0;
    tick;
    n_checks++;
    if ({wdata_ack, req_ready, busy} !== 6'b0000_1_0)
      $display("FAIL %s end: ack/ready/busy=%b expected 000010", name, {wdata_ack, req_ready, busy});
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_store   = 1'b0;
    req_addr    = '0;
    wdata       = '0;
    wdata_valid = 1'b0;
    #12;
    n_checks++;
    if ({req_ready, busy, rdata_valid, rdata_ack, wdata_ack} !== 11'b0 || rdata !== 32'h0)
      $display("FAIL reset: ready=%b busy=%b valid=%b rdata=%h rack=%b wack=%b expected all 0",
               req_ready, busy, rdata_valid, rdata, rdata_ack, wdata_ack);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL reset release: ready=%b expected 0 before edge", req_ready);
    else n_pass++;
    tick;
    n_checks++;
    if ({req_ready, busy} !== 2'b10)
      $display("FAIL reset first edge: ready/busy=%b expected 10", {req_ready, busy});
    else n_pass++;
  endtask

  task automatic test_write_read;
    do_write(32'h40, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, W, 0, "wr_0x40");
    do_read(32'h40, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, "rd_0x40");
  endtask

  task automatic test_critical_word;
    do_read(32'h48, {32'hA1, 32'hA0, 32'hA3, 32'hA2}, "cwf_0x48");
    do_read(32'h4F, {32'hA2, 32'hA1, 32'hA0, 32'hA3}, "cwf_0x4f");
  endtask

  task automatic test_wb_stall;
    do_write(32'h80, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 2, 2, "wr_stall_0x80");
    do_read(32'h80, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, "rd_stall_0x80");
  endtask

  task automatic test_addr_wrap;
    do_write(32'h400, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, W, 0, "wr_wrap_0x400");
    do_read(32'h000, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, "rd_wrap_0x000");
    do_read(32'h40, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, "rd_untouched_0x40");
  endtask

  task automatic test_busy_request;
    req_valid = 1'b1;
    req_store = 1'b0;
    req_addr  = 32'h40;
    tick;
    n_checks++;
    if ({req_ready, busy} !== 2'b01)
      $display("FAIL busy_req first accept: ready/busy=%b expected 01", {req_ready, busy});
    else n_pass++;
    req_addr = 32'h48;
    observe_read(2'd0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, "busy_req_first");
    tick;
    req_valid = 1'b0;
    n_checks++;
    if ({req_ready, busy} !== 2'b01)
      $display("FAIL busy_req second accept: ready/busy=%b expected 01", {req_ready, busy});
    else n_pass++;
    observe_read(2'd2, {32'hA1, 32'hA0, 32'hA3, 32'hA2}, "busy_req_second");
  endtask

  task automatic test_reset_mid_fill;
    accept(1'b0, 32'h80, "rst_fill");
    repeat (L + 2) tick;
    n_checks++;
    if (rdata_valid !== 1'b1 || rdata !== 32'hC1 || rdata_ack !== 4'b0010)
      $display("FAIL rst_fill beat1: valid=%b data=%h ack=%b expected 1 000000c1 0010",
               rdata_valid, rdata, rdata_ack);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, busy, rdata_valid, rdata_ack, wdata_ack} !== 11'b0 || rdata !== 32'h0)
      $display("FAIL rst_fill in reset: ready=%b busy=%b valid=%b rdata=%h rack=%b wack=%b expected all 0",
               req_ready, busy, rdata_valid, rdata, rdata_ack, wdata_ack);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    n_checks++;
    if ({req_ready, busy, rdata_valid} !== 3'b100)
      $display("FAIL rst_fill release: ready/busy/valid=%b expected 100", {req_ready, busy, rdata_valid});
    else n_pass++;
    do_read(32'h80, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, "rst_refill_0x80");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_critical_word();
    test_wb_stall();
    test_addr_wrap();
    test_busy_request();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
